// File: rtl/addr_chunked.sv
// addr_chunked: WIDTH-bit add/subtract unit. It adds CHUNK bits per clock,
// least significant chunk first, and keeps the carry in a register between
// chunks. Operands come in and results go out over valid/ready handshakes.
// It reports the raw carry-out and the two's-complement overflow.
module addr_chunked #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SUM_W  = CHUNK + 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bb_q, bb_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0]      bit_idx;
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] bb_k;
    logic [SUM_W-1:0] chunk_sum;

    // Select the chunk the counter points at and add it with the carry.
    assign bit_idx   = 32'(cnt_q) * 32'(CHUNK);
    assign a_k       = a_q[bit_idx +: CHUNK];
    assign bb_k      = bb_q[bit_idx +: CHUNK];
    assign chunk_sum = SUM_W'(a_k) + SUM_W'(bb_k) + SUM_W'(carry_q);

    // Accept new operands only in IDLE. Reset forces in_ready low at once.
    assign in_ready  = (state_q == IDLE) && !rst;

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Next-state logic and per-chunk datapath update.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        bb_d        = bb_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    bb_d    = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[bit_idx +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d               = chunk_sum[CHUNK];
                if (cnt_q == LAST_CHUNK) begin
                    // The carry into the MSB is recovered as a ^ bb ^ sum at that bit.
                    cout_d      = chunk_sum[CHUNK];
                    ovf_d       = a_k[CHUNK-1] ^ bb_k[CHUNK-1]
                                ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            bb_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            bb_q        <= bb_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
